// File: rtl/rate_counter_pkg.sv
// rtl/rate_counter_pkg.sv - shared digit type and BCD digit step helpers for rate_counter
package rate_counter_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t BCD_MAX = 4'd9;

    // Step one decimal digit upward when cin is set; returns {carry_out, digit}.
    // An out-of-range digit is treated as past 9, so it clears and carries.
    function automatic logic [4:0] bcd_digit_inc(input digit_t d, input logic cin);
        logic [4:0] r;
        if (!cin) begin
            r = {1'b0, d};
        end else if (d >= BCD_MAX) begin
            r = {1'b1, 4'd0};
        end else begin
            r = {1'b0, d + 4'd1};
        end
        return r;
    endfunction

    // Step one decimal digit downward when bin is set; returns {borrow_out, digit}.
    // An out-of-range digit snaps to 9 without borrowing from the next digit.
    function automatic logic [4:0] bcd_digit_dec(input digit_t d, input logic bin);
        logic [4:0] r;
        if (!bin) begin
            r = {1'b0, d};
        end else if (d == 4'd0) begin
            r = {1'b1, BCD_MAX};
        end else if (d > BCD_MAX) begin
            r = {1'b0, BCD_MAX};
        end else begin
            r = {1'b0, d - 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/rate_prescaler.sv
// rtl/rate_prescaler.sv - programmable-period prescaler producing a tick event
module rate_prescaler #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [DIV_W-1:0] period,
    input  logic             clear,
    output logic             tick_evt
);

    logic [DIV_W-1:0] pre;

    // The >= compare makes a period lowered below pre fire once and restart at 0.
    assign tick_evt = run && (pre >= period);

    // Prescaler state: restart on reset, clear or tick; otherwise advance while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
        end else if (clear) begin
            pre <= '0;
        end else if (tick_evt) begin
            pre <= '0;
        end else if (run) begin
            pre <= pre + DIV_W'(1);
        end
    end

endmodule

// File: rtl/rate_counter.sv
// rtl/rate_counter.sv - prescaled multi-digit hex/BCD up/down counter with wrap strobe
module rate_counter
    import rate_counter_pkg::*;
#(
    parameter int DIV_W   = 24,
    parameter int N_DIGIT = 8,
    parameter int CNT_W   = 4 * N_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] period,
    input  logic             run,
    input  logic             up,
    input  logic             bcd,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    logic             tick_evt;
    logic [CNT_W-1:0] next_count;
    logic             next_wrap;

    rate_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .period   (period),
        .clear    (load),
        .tick_evt (tick_evt)
    );

    // Next count value and wrap flag for one step in the current mode and direction.
    always_comb begin
        logic       chain;
        logic [4:0] res;
        next_count = count;
        next_wrap  = 1'b0;
        chain      = 1'b1;
        res        = '0;
        if (bcd) begin
            for (int i = 0; i < N_DIGIT; i++) begin
                if (up) begin
                    res = bcd_digit_inc(count[4*i +: 4], chain);
                end else begin
                    res = bcd_digit_dec(count[4*i +: 4], chain);
                end
                next_count[4*i +: 4] = res[3:0];
                chain                = res[4];
            end
            next_wrap = chain;
        end else if (up) begin
            next_count = count + CNT_W'(1);
            next_wrap  = &count;
        end else begin
            next_count = count - CNT_W'(1);
            next_wrap  = (count == '0);
        end
    end

    // Output registers: load beats a coincident tick, which is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_value;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else if (tick_evt) begin
            count <= next_count;
            tick  <= 1'b1;
            wrap  <= next_wrap;
        end else begin
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rate_counter.sv
// tb/tb_rate_counter.sv - directed self-checking bench for rate_counter
module tb_rate_counter;

    localparam int DIV_W   = 8;
    localparam int N_DIGIT = 2;
    localparam int CNT_W   = 4 * N_DIGIT;

    logic             clk = 1'b0;
    logic             rst;
    logic [DIV_W-1:0] period;
    logic             run;
    logic             up;
    logic             bcd;
    logic             load;
    logic [CNT_W-1:0] load_value;
    logic             tick;
    logic [CNT_W-1:0] count;
    logic             wrap;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic             load;
        logic [CNT_W-1:0] load_value;
        logic             bcd;
        logic             up;
        logic [CNT_W-1:0] exp_count;
        logic             exp_tick;
        logic             exp_wrap;
    } vec_t;

    vec_t vecs[$];

    rate_counter #(
        .DIV_W   (DIV_W),
        .N_DIGIT (N_DIGIT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .period     (period),
        .run        (run),
        .up         (up),
        .bcd        (bcd),
        .load       (load),
        .load_value (load_value),
        .tick       (tick),
        .count      (count),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [CNT_W-1:0] c, input logic t, input logic w);
        check({name, ".count"}, 32'(count), 32'(c));
        check({name, ".tick"}, 32'(tick), 32'(t));
        check({name, ".wrap"}, 32'(wrap), 32'(w));
    endtask

    task automatic add(input logic l, input logic [CNT_W-1:0] lv, input logic b, input logic u,
                       input logic [CNT_W-1:0] c, input logic t, input logic w);
        vec_t v;
        v.load = l; v.load_value = lv; v.bcd = b; v.up = u;
        v.exp_count = c; v.exp_tick = t; v.exp_wrap = w;
        vecs.push_back(v);
    endtask

    initial begin
        int tick_seen;

        // period=0, run=1 for every row: each non-load cycle is one step
        add(1, 8'h98, 1, 1, 8'h98, 0, 0);
        add(0, 8'h00, 1, 1, 8'h99, 1, 0);
        add(0, 8'h00, 1, 1, 8'h00, 1, 1);
        add(0, 8'h00, 1, 1, 8'h01, 1, 0);
        add(1, 8'h10, 1, 0, 8'h10, 0, 0);
        add(0, 8'h00, 1, 0, 8'h09, 1, 0);
        add(0, 8'h00, 1, 0, 8'h08, 1, 0);
        add(1, 8'h00, 1, 0, 8'h00, 0, 0);
        add(0, 8'h00, 1, 0, 8'h99, 1, 1);
        add(1, 8'h00, 0, 0, 8'h00, 0, 0);
        add(0, 8'h00, 0, 0, 8'hFF, 1, 1);
        add(0, 8'h00, 0, 1, 8'h00, 1, 1);
        add(1, 8'h42, 0, 1, 8'h42, 0, 0);
        add(0, 8'h00, 0, 1, 8'h43, 1, 0);
        add(1, 8'hFF, 0, 1, 8'hFF, 0, 0);
        add(1, 8'h05, 0, 1, 8'h05, 0, 0);
        add(1, 8'h3A, 1, 1, 8'h3A, 0, 0);
        add(0, 8'h00, 1, 1, 8'h40, 1, 0);
        add(1, 8'h3A, 1, 0, 8'h3A, 0, 0);
        add(0, 8'h00, 1, 0, 8'h39, 1, 0);
        add(1, 8'h19, 0, 1, 8'h19, 0, 0);
        add(0, 8'h00, 0, 1, 8'h1A, 1, 0);
        add(0, 8'h00, 1, 1, 8'h20, 1, 0);

        rst = 1; period = 8'd3; run = 1; up = 1; bcd = 0; load = 1; load_value = 8'h77;
        step();
        step();
        check_out("reset", 8'h00, 0, 0);

        // free run, period 3: tick every 4th cycle after reset release
        rst = 0; load = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            check($sformatf("free_run[%0d].tick", c), 32'(tick), 32'(c % 4 == 0));
            check($sformatf("free_run[%0d].count", c), 32'(count), 32'(c / 4));
        end

        // table-driven vectors
        period = 8'd0; run = 1;
        for (int i = 0; i < vecs.size(); i++) begin
            load = vecs[i].load; load_value = vecs[i].load_value;
            bcd = vecs[i].bcd; up = vecs[i].up;
            step();
            check_out($sformatf("vec[%0d]", i), vecs[i].exp_count, vecs[i].exp_tick, vecs[i].exp_wrap);
        end

        // pause at pre=5 with period 9, then shorten period below pre
        bcd = 0; up = 1; period = 8'd9; load = 1; load_value = 8'h00;
        step();
        load = 0;
        for (int c = 0; c < 5; c++) step();
        check_out("pre5", 8'h00, 0, 0);
        run = 0;
        tick_seen = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (tick === 1'b1 || count !== 8'h00) tick_seen++;
        end
        check("pause.no_tick", 32'(tick_seen), 32'd0);
        run = 1; period = 8'd2;
        step();
        check_out("resume.first", 8'h01, 1, 0);
        step();
        check("resume.gap1", 32'(tick), 32'd0);
        step();
        check("resume.gap2", 32'(tick), 32'd0);
        step();
        check_out("resume.second", 8'h02, 1, 0);

        // reset mid-count with coincident load
        period = 8'd0;
        step();
        rst = 1; load = 1; load_value = 8'h42;
        step();
        check_out("mid_reset", 8'h00, 0, 0);
        rst = 0; load = 0; period = 8'd2;
        step();
        check("post_reset.c1", 32'(tick), 32'd0);
        step();
        check("post_reset.c2", 32'(tick), 32'd0);
        step();
        check_out("post_reset.c3", 8'h01, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rate_counter.md
Name: rate_counter

Overview:
- Parametrised successor to the free-running clock-divider/slow-counter pair.
- Contains a programmable-period prescaler that generates a one-cycle tick. The tick drives a multi-digit counter with up/down, hex/BCD mode, run/pause, synchronous load and a wrap strobe.
- Sits between board controls (keys/switches) and the seven-segment display driver.
- Provides the time base for stopwatch/timer labs.

Parameters:
- DIV_W, 24, prescaler width; tick period is up to 2^DIV_W cycles.
- N_DIGIT, 8, number of 4-bit digits in the counter.
- CNT_W, 4*N_DIGIT, counter width (derived; do not override).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- period  input  DIV_W  tick period minus 1 (0 = tick every cycle)
- run  input  1  1 = prescaler advances; 0 = pause (hold)
- up  input  1  1 = count up, 0 = count down
- bcd  input  1  1 = decimal digits 0-9, 0 = hex modulo 2^CNT_W
- load  input  1  synchronous load strobe
- load_value  input  CNT_W  value written on load
- tick  output  1  registered one-cycle pulse, coincident with each count update
- count  output  CNT_W  registered counter value
- wrap  output  1  registered one-cycle pulse when count wraps

Behaviour:
- Reset (rst=1 at posedge): prescaler=0, count=0, tick=0, wrap=0. Reset overrides all inputs, including load.
- Prescaler:
  - run=1 and pre<period: pre<=pre+1.
  - run=1 and pre>=period: pre<=0, and a tick event occurs.
  - run=0: pre holds and no tick occurs.
  - period=0 with run=1 gives a tick every cycle.
  - If period is lowered below the current pre, the next run cycle takes the >= branch: one tick, then pre=0. There is no lost or extra wrap beyond that single tick.
- Tick timing: on a tick event, tick is asserted for the following cycle, and count/wrap update at the same edge. tick and wrap are therefore aligned with the new count.
- Counter step, hex mode: count±1 modulo 2^CNT_W.
  - Up from all-ones gives 0 with wrap=1.
  - Down from 0 gives all-ones with wrap=1.
- Counter step, BCD mode: per-digit 0-9 with ripple carry/borrow.
  - Up: 9 gives 0 plus a carry into the next digit. Top-digit carry-out means count=0 and wrap=1.
  - Down: 0 gives 9 plus a borrow. Top-digit borrow-out means all digits are 9 and wrap=1.
  - Invalid digit (>9) on up: becomes 0 and generates a carry.
  - Invalid digit (>9) on down: becomes 9 with no borrow.
  - Invalid digits are only reachable via load or a mode switch.
- Mode or direction change takes effect on the next tick. The stored count is never rewritten by the mode switch itself.
- Load priority: if load=1, then count<=load_value, pre<=0, tick<=0 and wrap<=0, regardless of run or a coincident tick event (the tick is dropped). count reflects load_value one cycle after load.
- Outputs: all outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package rate_counter_pkg contains:
  - typedef digit_t (logic [3:0]);
  - localparam BCD_MAX = 4'd9;
  - functions bcd_digit_inc and bcd_digit_dec, each returning a {carry/borrow, digit} pair.
- Sub-module rate_prescaler holds the DIV_W counter plus tick-event generation, with ports clk, rst, run, period, clear, tick_evt.
- The top-level block contains the digit chain and output registers.

Test Plan:
- Free run: period=3, run=1, up=1, bcd=0, reset released → tick every 4th cycle; count reads 1, 2, 3 on successive ticks; first tick appears 4 cycles after reset deasserts.
- BCD rollover: N_DIGIT=2, load 8'h98, period=0, bcd=1, up=1 → count 99, then 00 with wrap=1 in the same cycle as tick, then 01.
- Down/borrow: bcd=1, load 8'h10, up=0, period=0 → 09, 08; after load 8'h00 → 99 with wrap=1. With bcd=0 and load 0 → FF with wrap=1.
- Pause/period change: period=9; drop run for 20 cycles at pre=5 → no ticks and count frozen. Resume, then set period=2 while pre=5 → tick on the next cycle, then every 3 cycles.
- Load vs tick collision: period=0, run=1, assert load with load_value=8'h42 → count=42 on the next cycle with tick=0, wrap=0; increments resume afterwards (43).
- Reset mid-operation: assert rst during counting with load=1 simultaneously → count=0, tick=0, wrap=0 and prescaler restarts; the first tick occurs period+1 cycles after rst falls.
